// File: rtl/reg_pkg.sv
// Shared types and helpers for the register-bank read port.
package reg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_t;

    // Index width for a bank of n registers; never narrower than one bit.
    function automatic int REG_ADDR_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_slice_mux.sv
// Combinational selector: picks one register slice from the flat bank bus
// and flags indices that fall outside the bank.
module reg_slice_mux
    import reg_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REG    = 6,
    parameter int ADDR_WIDTH = REG_ADDR_W(NUM_REG)
) (
    input  logic [NUM_REG*DATA_WIDTH-1:0] reg_data,
    input  logic [ADDR_WIDTH-1:0]         idx,
    output logic [DATA_WIDTH-1:0]         data,
    output logic                          err
);

    // Loop compare keeps out-of-range indices from ever addressing past the bus.
    always_comb begin
        data = '0;
        err  = 1'b1;
        for (int k = 0; k < NUM_REG; k++) begin
            if (32'(idx) == k) begin
                data = reg_data[k*DATA_WIDTH +: DATA_WIDTH];
                err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_read_port.sv
// Valid/ready read port over a flat register bank: single reads and bursts
// that stream consecutive registers up to the top of the bank.
module reg_read_port
    import reg_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_REG    = 6,
    localparam int ADDR_WIDTH = REG_ADDR_W(NUM_REG)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REG*DATA_WIDTH-1:0] i_reg_data,
    input  logic                          i_req_valid,
    output logic                          o_req_ready,
    input  logic [ADDR_WIDTH-1:0]         i_req_addr,
    input  logic                          i_req_burst,
    output logic                          o_rsp_valid,
    input  logic                          i_rsp_ready,
    output logic [DATA_WIDTH-1:0]         o_rsp_data,
    output logic [ADDR_WIDTH-1:0]         o_rsp_addr,
    output logic                          o_rsp_err,
    output logic                          o_rsp_last,
    output logic                          o_busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REG - 1);

    rd_state_t               state, state_nxt;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0]   req_data, cnt_data;
    logic                    req_err, cnt_err;
    logic                    advance, accept, load;
    logic [DATA_WIDTH-1:0]   ld_data;
    logic [ADDR_WIDTH-1:0]   ld_addr;
    logic                    ld_err, ld_last;

    reg_slice_mux #(.DATA_WIDTH(DATA_WIDTH), .NUM_REG(NUM_REG), .ADDR_WIDTH(ADDR_WIDTH)) u_req_mux (
        .reg_data (i_reg_data),
        .idx      (i_req_addr),
        .data     (req_data),
        .err      (req_err)
    );

    reg_slice_mux #(.DATA_WIDTH(DATA_WIDTH), .NUM_REG(NUM_REG), .ADDR_WIDTH(ADDR_WIDTH)) u_cnt_mux (
        .reg_data (i_reg_data),
        .idx      (cnt),
        .data     (cnt_data),
        .err      (cnt_err)
    );

    // The response register can take a new beat when empty or being drained.
    assign advance     = !o_rsp_valid || i_rsp_ready;
    assign o_req_ready = (state == IDLE) && advance;
    assign accept      = i_req_valid && o_req_ready;
    assign o_busy      = (state == BURST);

    // NOTE: every output of this block is assigned a default first, so no path leaves a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        ld_data   = '0;
        ld_addr   = '0;
        ld_err    = 1'b0;
        ld_last   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    ld_addr = i_req_addr;
                    ld_last = 1'b1;
                    if (req_err) begin
                        ld_err = 1'b1;
                    end else begin
                        ld_data = req_data;
                        if (i_req_burst) begin
                            cnt_nxt = i_req_addr + ADDR_WIDTH'(1);
                            if (i_req_addr != LAST_IDX) begin
                                ld_last   = 1'b0;
                                state_nxt = BURST;
                            end
                        end
                    end
                end
            end
            BURST: begin
                if (advance) begin
                    load    = 1'b1;
                    ld_addr = cnt;
                    ld_data = cnt_data;
                    ld_err  = cnt_err;
                    ld_last = (cnt == LAST_IDX);
                    cnt_nxt = cnt + ADDR_WIDTH'(1);
                    if (cnt == LAST_IDX) state_nxt = IDLE;
                end
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_addr  <= '0;
            o_rsp_err   <= 1'b0;
            o_rsp_last  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load) begin
                o_rsp_valid <= 1'b1;
                o_rsp_data  <= ld_data;
                o_rsp_addr  <= ld_addr;
                o_rsp_err   <= ld_err;
                o_rsp_last  <= ld_last;
            end else if (i_rsp_ready) begin
                o_rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_read_port.sv
// Self-checking bench for reg_read_port: directed scenarios followed by random
// traffic, compared against a queue of expected response beats.
module tb_reg_read_port;

    localparam int DW = 8;
    localparam int NR = 6;
    localparam int AW = 3;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic          err;
        logic          last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR*DW-1:0] i_reg_data;
    logic             i_req_valid;
    logic             o_req_ready;
    logic [AW-1:0]    i_req_addr;
    logic             i_req_burst;
    logic             o_rsp_valid;
    logic             i_rsp_ready;
    logic [DW-1:0]    o_rsp_data;
    logic [AW-1:0]    o_rsp_addr;
    logic             o_rsp_err;
    logic             o_rsp_last;
    logic             o_busy;

    logic [DW-1:0] regs [NR];
    beat_t         exp_q [$];
    int            n_pass  = 0;
    int            n_total = 0;

    always #5 clk = ~clk;

    always_comb begin
        i_reg_data = '0;
        for (int k = 0; k < NR; k++) i_reg_data[k*DW +: DW] = regs[k];
    end

    reg_read_port #(.DATA_WIDTH(DW), .NUM_REG(NR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_reg_data  (i_reg_data),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_addr  (i_req_addr),
        .i_req_burst (i_req_burst),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_data  (o_rsp_data),
        .o_rsp_addr  (o_rsp_addr),
        .o_rsp_err   (o_rsp_err),
        .o_rsp_last  (o_rsp_last),
        .o_busy      (o_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Beats a request produces, computed from the bank contents at acceptance.
    task automatic push_request(input logic [AW-1:0] a, input logic burst);
        beat_t b;
        if (int'(a) >= NR) begin
            b = '{data: '0, addr: a, err: 1'b1, last: 1'b1};
            exp_q.push_back(b);
        end else if (!burst) begin
            b = '{data: regs[a], addr: a, err: 1'b0, last: 1'b1};
            exp_q.push_back(b);
        end else begin
            for (int i = int'(a); i < NR; i++) begin
                b = '{data: regs[i], addr: AW'(i), err: 1'b0, last: (i == NR - 1)};
                exp_q.push_back(b);
            end
        end
    endtask

    // One cycle, entered and left at a falling edge.
    task automatic step(input logic rv, input logic [AW-1:0] ra, input logic rb, input logic rr);
        int   pend;
        logic exp_rdy;
        pend = exp_q.size();
        check("rsp_valid", o_rsp_valid, pend > 0);
        check("busy", o_busy, pend >= 2);
        if (pend > 0) begin
            check("rsp_data", o_rsp_data, exp_q[0].data);
            check("rsp_addr", o_rsp_addr, exp_q[0].addr);
            check("rsp_err", o_rsp_err, exp_q[0].err);
            check("rsp_last", o_rsp_last, exp_q[0].last);
        end
        i_req_valid = rv;
        i_req_addr  = ra;
        i_req_burst = rb;
        i_rsp_ready = rr;
        #1;
        exp_rdy = (pend == 0) || (pend == 1 && rr);
        check("req_ready", o_req_ready, exp_rdy);
        if (pend > 0 && rr) void'(exp_q.pop_front());
        if (rv && exp_rdy) push_request(ra, rb);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        i_req_valid = 1'b0;
        i_req_addr  = '0;
        i_req_burst = 1'b0;
        i_rsp_ready = 1'b0;
        foreach (regs[k]) regs[k] = '0;
        #12;
        check("rst_valid", o_rsp_valid, 0);
        check("rst_data", o_rsp_data, 0);
        check("rst_addr", o_rsp_addr, 0);
        check("rst_err", o_rsp_err, 0);
        check("rst_last", o_rsp_last, 0);
        check("rst_busy", o_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_req_ready", o_req_ready, 1);
        @(negedge clk);

        // Single read of register 2.
        regs[2] = 8'hAA;
        step(1, 2, 0, 1);
        step(0, 0, 0, 1);

        // Full burst from 1 with continuous ready.
        foreach (regs[k]) regs[k] = DW'(8'h10 + k);
        step(1, 1, 1, 1);
        repeat (5) step(0, 0, 0, 1);

        // Same burst under back-pressure, with a request waiting throughout.
        step(1, 1, 1, 1);
        for (int i = 0; i < 14; i++) step(1, 0, 0, (i % 3) == 0);
        repeat (2) step(0, 0, 0, 1);

        // Out-of-range single and burst.
        step(1, 6, 0, 1);
        step(1, 7, 1, 1);
        repeat (2) step(0, 0, 0, 1);

        // Back-to-back singles.
        step(1, 0, 0, 1);
        step(1, 3, 0, 1);
        step(1, 5, 0, 1);
        step(0, 0, 0, 1);

        // Reset while the second burst beat is on the bus.
        step(1, 0, 1, 1);
        step(0, 0, 0, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", o_rsp_valid, 0);
        check("mid_rst_data", o_rsp_data, 0);
        check("mid_rst_addr", o_rsp_addr, 0);
        check("mid_rst_last", o_rsp_last, 0);
        check("mid_rst_busy", o_busy, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step(1, 4, 0, 1);
        step(0, 0, 0, 1);

        // Random traffic; bank contents change only while no beat is still to be loaded.
        repeat (600) begin
            if (exp_q.size() <= 1 && $urandom_range(0, 3) == 0)
                foreach (regs[k]) regs[k] = DW'($urandom);
            step($urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
        end
        repeat (8) step(0, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
